ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
- Configuration-chain driver sitting directly upstream of a switch-block ccff chain; it feeds ccff_head and gates shifting.
- Accepts a configuration bitstream as WORD_W-bit words over a valid/ready handshake and serialises it MSB-first into the chain.
- Counts exactly CHAIN_LEN shifts, then stops.
- Captures the previous configuration as it emerges from ccff_tail and returns it as readback words.

Parameters:
- CHAIN_LEN, 24: total chain flops (9 size-2 mems × 2 bits + 2 size-7 mems × 3 bits).
- WORD_W, 8: bitstream word width.
- CNT_W, $clog2(CHAIN_LEN+1): localparam width of the shift counter.

Ports:
- prog_clk  in  1  configuration clock; the only clock.
- prog_reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE.
- word_in  in  WORD_W  bitstream word.
- word_valid  in  1  word_in valid.
- word_ready  out  1  loader accepts word_in this cycle.
- ccff_head  out  1  serial bit into the chain head.
- ccff_shift_en  out  1  chain clock enable; the chain shifts on a prog_clk edge only when this is 1.
- ccff_tail  in  1  chain tail output.
- rb_data  out  WORD_W  readback word.
- rb_valid  out  1  one-cycle strobe; rb_data valid. No backpressure.
- busy  out  1  state ≠ IDLE/DONE.
- done  out  1  sticky high from completion until the next start or reset.
- shift_count  out  CNT_W  bits shifted so far in this load.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all outputs 0; shift_count=0; internal shift register and readback register cleared.
- prog_reset dominates every other input in the same cycle. Reset mid-load aborts immediately: ccff_shift_en=0 in the next cycle, and the partial chain contents are left as-is.
- State IDLE:
  - start=1 → WAIT; done cleared; shift_count cleared.
  - word_ready=0.
- State WAIT:
  - word_ready=1.
  - On word_valid & word_ready: latch word_in into shreg, set bit_idx=WORD_W-1, go to SHIFT.
  - word_ready is combinational from state only, never from word_valid.
- State SHIFT:
  - ccff_head=shreg[WORD_W-1] and ccff_shift_en=1, both registered outputs valid during the SHIFT cycle.
  - Each SHIFT cycle: shreg shifts left by 1; shift_count increments; ccff_tail is sampled into rbreg LSB-side (rbreg shifts left, rbreg[0]=ccff_tail).
  - Latency: one bit per cycle. A full word takes WORD_W cycles, with no bubble if the next word is already valid.
- Word boundary, after WORD_W bits of the current word:
  - rb_valid=1 for one cycle with rb_data=rbreg.
  - If shift_count<CHAIN_LEN: return to WAIT. word_ready is asserted in that same cycle (look-ahead), so back-to-back words sustain 1 bit/cycle.
- Completion, when shift_count reaches CHAIN_LEN:
  - If mid-word: the remaining bits of that word are discarded, never shifted.
  - The partial readback word is emitted left-aligned, zero-padded in the low bits, with rb_valid=1.
  - ccff_shift_en=0 from the next cycle.
  - Go to DONE.
- State DONE:
  - done=1; word_ready=0; extra words are not accepted.
  - start → WAIT, exactly as from IDLE.
- start while busy is ignored with no side effect.
- word_valid dropping in WAIT stalls with ccff_shift_en=0; chain contents are held.
- Bit ordering:
  - The first bit shifted is word_in[WORD_W-1] of word 0.
  - After CHAIN_LEN shifts, the first bit sits in the tail-end flop; bit CHAIN_LEN-1 sits in the head flop.
- shift_count saturates at CHAIN_LEN and never wraps.

Decomposition:
- Shared package ccff_pkg holds:
  - the state enum (IDLE, WAIT, SHIFT, DONE);
  - the CHAIN_LEN default constant per tile type (sb_0__0_=24);
  - a ccff_word_t typedef.
- One natural sub-module, ccff_piso_sipo: a WORD_W shift register pair that handles serialise-out and deserialise-readback, with load/shift enables. The FSM and counter stay in the top module.

Test Plan (CHAIN_LEN=24, WORD_W=8, behavioural 24-flop chain model with enable):
- Reset then idle → all outputs 0; word_ready=0; no shifts for 20 cycles.
- start, then words 0xA5, 0x3C, 0xF0 back-to-back → 24 consecutive ccff_shift_en cycles, head sequence 10100101 00111100 11110000; done=1; model chain holds 0xA53CF0 (tail-end first).
- Preload chain with 0x123456, then load 0xFFFFFF → rb_valid three times with rb_data 0x12, 0x34, 0x56; shift_count=24.
- CHAIN_LEN=20, words 0xAA, 0xAA, 0xAB → exactly 20 shifts; last word's low 4 bits dropped; final rb_data left-aligned with low nibble 0; word_ready=0 after done.
- word_valid gap of 5 cycles between words → ccff_shift_en=0 for the gap; chain unchanged; total shifts still 24.
- prog_reset asserted after 10 shifts → next cycle: state IDLE, ccff_shift_en=0, shift_count=0, done=0; a subsequent start performs a full 24-bit load.

Source files
------------

// File: rtl/ccff_pkg.sv
// Shared types and per-tile chain lengths for the ccff configuration-chain loader.
package ccff_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, SHIFT, DONE} ccff_state_e;

  localparam int CCFF_WORD_W = 8;
  // sb_0__0_: 9 size-2 mems x 2 bits + 2 size-7 mems x 3 bits
  localparam int SB_0__0_CHAIN_LEN = 24;

  typedef logic [CCFF_WORD_W-1:0] ccff_word_t;
endpackage

// File: rtl/ccff_chain_loader_if.sv
// Bitstream word stream into the loader plus the readback word stream out of it.
interface ccff_chain_loader_if #(parameter int WORD_W = 8);
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;
  logic [WORD_W-1:0] rb_data;
  logic              rb_valid;

  modport master (output word_in, word_valid, input word_ready, rb_data, rb_valid);
  modport slave  (input word_in, word_valid, output word_ready, rb_data, rb_valid);
endinterface

// File: rtl/ccff_piso_sipo.sv
// Word shift register pair: serialises the load word MSB-first and collects the tail bits back.
module ccff_piso_sipo #(
  parameter int  WORD_W = 8,
  localparam int IDX_W  = $clog2(WORD_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] load_data,
  input  logic              ser_in,
  input  logic [IDX_W-1:0]  align_amt,
  output logic              ser_out,
  output logic [WORD_W-1:0] par_out
);
  logic [WORD_W-1:0] shreg, rbreg, rb_nxt;

  assign rb_nxt = {rbreg[WORD_W-2:0], ser_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      rbreg <= '0;
    end else begin
      if (load)       shreg <= load_data;
      else if (shift) shreg <= {shreg[WORD_W-2:0], 1'b0};
      // align_amt is nonzero only on a truncated final word: left-justify it, zero fill
      if (shift)      rbreg <= rb_nxt << align_amt;
    end
  end

  assign ser_out = shreg[WORD_W-1];
  assign par_out = rbreg;
endmodule

// File: rtl/ccff_chain_loader.sv
// Drives a ccff chain from a word stream: one bit per cycle, exactly CHAIN_LEN shifts, with readback.
module ccff_chain_loader import ccff_pkg::*; #(
  parameter int  CHAIN_LEN = SB_0__0_CHAIN_LEN,
  parameter int  WORD_W    = CCFF_WORD_W,
  localparam int CNT_W     = $clog2(CHAIN_LEN+1),
  localparam int IDX_W     = $clog2(WORD_W)
) (
  input  logic                prog_clk,
  input  logic                prog_reset,
  input  logic                start,
  ccff_chain_loader_if.slave  bus,
  output logic                ccff_head,
  output logic                ccff_shift_en,
  input  logic                ccff_tail,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    shift_count
);
  ccff_state_e      state, state_nxt;
  logic [IDX_W-1:0] bit_idx, align_amt;
  logic             rb_valid_q, last_bit, last_shift, accept, start_ok, ser_out;

  assign last_bit   = (bit_idx == '0);
  assign last_shift = (state == SHIFT) && (shift_count == CNT_W'(CHAIN_LEN-1));
  assign start_ok   = start && ((state == IDLE) || (state == DONE));
  assign accept     = bus.word_valid && bus.word_ready;
  assign align_amt  = last_shift ? bit_idx : '0;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = WAIT;
      WAIT:       if (accept) state_nxt = SHIFT;
      SHIFT: begin
        if (last_shift)    state_nxt = DONE;
        else if (last_bit) state_nxt = accept ? SHIFT : WAIT;
      end
      default:    state_nxt = IDLE;
    endcase
  end

  // word_ready looks ahead on the last bit of a word so consecutive words carry no bubble
  always_comb begin
    bus.word_ready = 1'b0;
    ccff_shift_en  = 1'b0;
    busy           = 1'b0;
    case (state)
      WAIT: begin
        bus.word_ready = 1'b1;
        busy           = 1'b1;
      end
      SHIFT: begin
        bus.word_ready = last_bit && !last_shift;
        ccff_shift_en  = 1'b1;
        busy           = 1'b1;
      end
      default: ;
    endcase
    ccff_head = ccff_shift_en & ser_out;
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      bit_idx     <= '0;
      shift_count <= '0;
      done        <= 1'b0;
      rb_valid_q  <= 1'b0;
    end else begin
      rb_valid_q <= (state == SHIFT) && (last_bit || last_shift);
      if (start_ok) begin
        shift_count <= '0;
        done        <= 1'b0;
      end else if (state == SHIFT && shift_count != CNT_W'(CHAIN_LEN)) begin
        shift_count <= shift_count + CNT_W'(1);
      end
      if (last_shift) done <= 1'b1;
      if (accept)                           bit_idx <= IDX_W'(WORD_W-1);
      else if (state == SHIFT && !last_bit) bit_idx <= bit_idx - IDX_W'(1);
    end
  end

  assign bus.rb_valid = rb_valid_q;

  ccff_piso_sipo #(.WORD_W(WORD_W)) u_piso_sipo (
    .clk       (prog_clk),
    .rst       (prog_reset),
    .load      (accept),
    .shift     (state == SHIFT),
    .load_data (bus.word_in),
    .ser_in    (ccff_tail),
    .align_amt (align_amt),
    .ser_out   (ser_out),
    .par_out   (bus.rb_data)
  );
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Two loaders (24- and 20-flop chains) on one stimulus stream, each feeding a behavioural chain.
module tb_ccff_chain_loader;
  import ccff_pkg::*;
  localparam int W = 8, L0 = 24, L1 = 20;
  localparam int CW0 = $clog2(L0+1), CW1 = $clog2(L1+1);

  logic clk = 1'b0, rst, start, wvalid, pre_en;
  ccff_word_t win;
  logic [1:0] head, sen, tail, busy, done;
  logic [CW0-1:0] cnt0;
  logic [CW1-1:0] cnt1;
  logic [23:0] ch [2];
  logic [23:0] pre_val [2];
  logic [23:0] exp_ch [2];
  bit hq0[$], hq1[$];
  ccff_word_t rq0[$], rq1[$];
  int checks = 0, failures = 0;
  int nsh [2] = '{0, 0};
  time last_sh [2];

  always #5 clk = ~clk;

  ccff_chain_loader_if #(.WORD_W(W)) bus0 ();
  ccff_chain_loader_if #(.WORD_W(W)) bus1 ();
  assign bus0.word_in = win;  assign bus0.word_valid = wvalid;
  assign bus1.word_in = win;  assign bus1.word_valid = wvalid;
  assign tail[0] = ch[0][L0-1];
  assign tail[1] = ch[1][L1-1];

  ccff_chain_loader #(.CHAIN_LEN(L0), .WORD_W(W)) dut0 (
    .prog_clk(clk), .prog_reset(rst), .start(start), .bus(bus0),
    .ccff_head(head[0]), .ccff_shift_en(sen[0]), .ccff_tail(tail[0]),
    .busy(busy[0]), .done(done[0]), .shift_count(cnt0));
  ccff_chain_loader #(.CHAIN_LEN(L1), .WORD_W(W)) dut1 (
    .prog_clk(clk), .prog_reset(rst), .start(start), .bus(bus1),
    .ccff_head(head[1]), .ccff_shift_en(sen[1]), .ccff_tail(tail[1]),
    .busy(busy[1]), .done(done[1]), .shift_count(cnt1));

  // chain: bit 0 is the head flop, bit L-1 the tail-end flop
  always @(posedge clk) begin
    if (pre_en) begin
      ch[0] <= pre_val[0];
      ch[1] <= pre_val[1];
    end else begin
      if (sen[0]) ch[0] <= {ch[0][22:0], head[0]};
      if (sen[1]) ch[1] <= {ch[1][22:0], head[1]};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (sen[0]) begin
      nsh[0]++; last_sh[0] = $time;
      if (hq0.size() == 0) chk("extra_shift0", 1, 0); else chk("head0", head[0], hq0.pop_front());
    end
    if (bus0.rb_valid) begin
      if (rq0.size() == 0) chk("extra_rb0", 1, 0); else chk("rb0", bus0.rb_data, rq0.pop_front());
    end
    if (sen[1]) begin
      nsh[1]++; last_sh[1] = $time;
      if (hq1.size() == 0) chk("extra_shift1", 1, 0); else chk("head1", head[1], hq1.pop_front());
    end
    if (bus1.rb_valid) begin
      if (rq1.size() == 0) chk("extra_rb1", 1, 0); else chk("rb1", bus1.rb_data, rq1.pop_front());
    end
  end

  // Reference: first L stream bits enter MSB-first; the old contents leave tail-first as readback.
  task automatic push_exp(input logic [23:0] stream);
    logic [23:0] old;
    int len;
    ccff_word_t w;
    for (int d = 0; d < 2; d++) begin
      len = (d == 0) ? L0 : L1;
      old = ch[d];
      for (int i = 0; i < len; i++)
        if (d == 0) hq0.push_back(stream[23-i]); else hq1.push_back(stream[23-i]);
      for (int k = 0; k < (len+W-1)/W; k++) begin
        w = '0;
        for (int b = 0; b < W; b++)
          if (k*W+b < len) w[W-1-b] = old[len-1-(k*W+b)];
        if (d == 0) rq0.push_back(w); else rq1.push_back(w);
      end
      exp_ch[d] = stream >> (24-len);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic preload(input logic [23:0] v0, input logic [23:0] v1);
    pre_val[0] = v0; pre_val[1] = v1; pre_en = 1'b1; tick(); pre_en = 1'b0;
  endtask

  task automatic send_word(input ccff_word_t w, input int gap);
    int t;
    logic [23:0] snap;
    if (gap > 0) begin
      wvalid = 1'b0;
      t = 0;
      do begin @(negedge clk); t++; end while (!bus0.word_ready && t < 50);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        if (g == 0) snap = ch[0];
        chk("gap_shift_en", sen[0], 0);
        chk("gap_chain_held", ch[0], snap);
      end
      tick();
    end
    win = w; wvalid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (bus0.word_ready) break;
      if (++t > 50) begin chk("ready_timeout", 0, 1); break; end
    end
    tick();
  endtask

  task automatic load(input logic [23:0] stream, input int gap);
    int base0, base1, t;
    time t_first;
    push_exp(stream);
    base0 = nsh[0]; base1 = nsh[1];
    pulse_start();
    @(negedge clk);
    chk("start_done_cnt", {done, 3'b0, cnt0, 3'b0, cnt1}, 0);
    chk("start_busy_ready", {busy, bus1.word_ready, bus0.word_ready}, 4'hF);
    tick();
    for (int k = 0; k < 3; k++) begin
      send_word(stream[23-8*k -: 8], gap);
      if (k == 0) t_first = $time + 4;
    end
    wvalid = 1'b0;
    t = 0;
    while (!done[0] && t < 200) begin @(negedge clk); t++; end
    chk("done_timeout", t < 200, 1);
    @(negedge clk);
    chk("done0", done[0], 1);
    chk("cnt0", cnt0, L0);
    chk("after_done0", {sen[0], busy[0], bus0.word_ready}, 0);
    chk("chain0", ch[0], exp_ch[0]);
    chk("nshift0", nsh[0] - base0, L0);
    chk("queue0_empty", hq0.size() + rq0.size(), 0);
    chk("done1", done[1], 1);
    chk("cnt1", cnt1, L1);
    chk("after_done1", {sen[1], busy[1], bus1.word_ready}, 0);
    chk("chain1", ch[1][L1-1:0], exp_ch[1]);
    chk("nshift1", nsh[1] - base1, L1);
    chk("queue1_empty", hq1.size() + rq1.size(), 0);
    if (gap == 0) begin
      chk("run0", 32'(last_sh[0] - t_first), 230);
      chk("run1", 32'(last_sh[1] - t_first), 190);
    end
    tick();
  endtask

  initial begin
    logic [23:0] pv;
    ccff_word_t w;
    int base, t;
    logic [CW0-1:0] c;
    rst = 1'b1; start = 1'b0; wvalid = 1'b0; win = '0; pre_en = 1'b0;
    pre_val[0] = '0; pre_val[1] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    pv = 24'($urandom);
    preload(pv, 24'($urandom));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle0", {sen[0], head[0], busy[0], done[0], cnt0, bus0.word_ready, bus0.rb_valid, bus0.rb_data}, 0);
      chk("idle1", {sen[1], head[1], busy[1], done[1], cnt1, bus1.word_ready, bus1.rb_valid, bus1.rb_data}, 0);
      chk("idle_chain", ch[0], pv);
    end
    tick();

    load(24'hA53CF0, 0);
    chk("chain_a53cf0", ch[0], 24'hA53CF0);
    preload(24'h123456, 24'h0ABCDE);
    load(24'hFFFFFF, 0);
    load(24'hAAAAAB, 0);
    load(24'($urandom), 5);

    // mid-load: a stray start is ignored, then reset aborts after ten shifts
    w = ccff_word_t'($urandom);
    push_exp({w, w, w});
    base = nsh[0];
    pulse_start();
    win = w; wvalid = 1'b1;
    t = 0;
    while (nsh[0] - base < 4 && t < 100) begin @(negedge clk); #1; t++; end
    c = cnt0;
    start = 1'b1; tick(); start = 1'b0;
    @(negedge clk);
    chk("start_while_busy", {busy[0], done[0], cnt0}, {1'b1, 1'b0, c + CW0'(1)});
    t = 0;
    while (nsh[0] - base < 10 && t < 100) begin @(negedge clk); #1; t++; end
    chk("abort_timeout", t < 100, 1);
    rst = 1'b1;
    tick();
    hq0.delete(); hq1.delete(); rq0.delete(); rq1.delete();
    @(negedge clk);
    chk("abort0", {sen[0], busy[0], done[0], cnt0, bus0.word_ready, bus0.rb_valid}, 0);
    chk("abort1", {sen[1], busy[1], done[1], cnt1, bus1.word_ready, bus1.rb_valid}, 0);
    tick();
    rst = 1'b0; wvalid = 1'b0;

    load(24'($urandom), 0);
    repeat (6) load(24'($urandom), $urandom_range(0, 3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
